// File: rtl/ram_dualport_param.sv
// ram_dualport_param: true dual-port RAM with self-clear after reset and collision flag.
// Latency: 1 cycle from accepting edge (OUT_REG=0) or 2 cycles (OUT_REG=1); one access per port per cycle.
// Backpressure: none; accesses are dropped while busy (memory clear in progress).
//
// Ports:
//   clk, rst                  : single rising-edge clock, synchronous active-high reset
//   en_x, we_x, addr_x        : per-port enable, write select, word address
//   data_in_x / data_out_x    : write data / read or write-through data
//   valid_x                   : data_out_x carries the result of an accepted access
//   busy                      : memory clear running; accesses ignored
//   collision                 : one-cycle pulse on same-address conflict with a write
module ram_dualport_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_in_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_a,
  output logic              valid_b,
  output logic              busy,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic STATE_CLEAR = 1'b0;
  localparam logic STATE_READY = 1'b1;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  logic              state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_a, acc_b;
  logic [DATA_W-1:0] res_a, res_b;
  logic              hit;

  assign busy  = (state == STATE_CLEAR);
  assign acc_a = !busy && en_a;
  assign acc_b = !busy && en_b;

  // Reads see the array before this edge's writes, which gives read-first
  // behaviour across ports for free. Write-first only substitutes own data_in.
  assign res_a = (RDW_MODE == 0 && we_a) ? data_in_a : mem[addr_a];
  assign res_b = (RDW_MODE == 0 && we_b) ? data_in_b : mem[addr_b];
  assign hit   = acc_a && acc_b && (addr_a == addr_b) && (we_a || we_b);

  // Control FSM: CLEAR walks every word once, then READY until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STATE_CLEAR;
      clr_cnt <= '0;
    end else if (state == STATE_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == CNT_LAST) state <= STATE_READY;
    end
  end

  // Storage. Port A is written last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[clr_cnt[ADDR_W-1:0]] <= '0;
      end else begin
        if (acc_b && we_b) mem[addr_b] <= data_in_b;
        if (acc_a && we_a) mem[addr_a] <= data_in_a;
      end
    end
  end

  // First output stage. Data only moves on an accepted access so an idle
  // port holds its last result while valid drops.
  logic [DATA_W-1:0] d1_a, d1_b;
  logic              v1_a, v1_b, c1;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_a <= '0;
      d1_b <= '0;
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      c1   <= 1'b0;
    end else begin
      v1_a <= acc_a;
      v1_b <= acc_b;
      c1   <= hit;
      if (acc_a) d1_a <= res_a;
      if (acc_b) d1_b <= res_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] d2_a, d2_b;
      logic              v2_a, v2_b, c2;

      always_ff @(posedge clk) begin
        if (rst) begin
          d2_a <= '0;
          d2_b <= '0;
          v2_a <= 1'b0;
          v2_b <= 1'b0;
          c2   <= 1'b0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          c2   <= c1;
          if (v1_a) d2_a <= d1_a;
          if (v1_b) d2_b <= d1_b;
        end
      end

      assign data_out_a = d2_a;
      assign data_out_b = d2_b;
      assign valid_a    = v2_a;
      assign valid_b    = v2_b;
      assign collision  = c2;
    end else begin : g_no_out_reg
      assign data_out_a = d1_a;
      assign data_out_b = d1_b;
      assign valid_a    = v1_a;
      assign valid_b    = v1_b;
      assign collision  = c1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dualport_param.sv
// tb_ram_dualport_param: directed table-driven bench for ram_dualport_param.
// Latency: u0 (write-first, no out reg) checks at +1, u1 (read-first, out reg) at +2.
// Backpressure: none; reset/clear sequences are bounded by a cycle budget.
module tb_ram_dualport_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u0: RDW_MODE=0, OUT_REG=0 ; u1: RDW_MODE=1, OUT_REG=1
  logic       en_a0, we_a0, en_b0, we_b0, en_a1, we_a1, en_b1, we_b1;
  logic [4:0] addr_a0, addr_b0, addr_a1, addr_b1;
  logic [7:0] din_a0, din_b0, din_a1, din_b1;
  logic [7:0] da0, db0, da1, db1;
  logic       va0, vb0, va1, vb1, busy0, busy1, col0, col1;

  ram_dualport_param #(.DATA_W(8), .ADDR_W(5), .RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst),
    .en_a(en_a0), .we_a(we_a0), .addr_a(addr_a0), .data_in_a(din_a0),
    .en_b(en_b0), .we_b(we_b0), .addr_b(addr_b0), .data_in_b(din_b0),
    .data_out_a(da0), .data_out_b(db0), .valid_a(va0), .valid_b(vb0),
    .busy(busy0), .collision(col0));

  ram_dualport_param #(.DATA_W(8), .ADDR_W(5), .RDW_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst),
    .en_a(en_a1), .we_a(we_a1), .addr_a(addr_a1), .data_in_a(din_a1),
    .en_b(en_b1), .we_b(we_b1), .addr_b(addr_b1), .data_in_b(din_b1),
    .data_out_a(da1), .data_out_b(db1), .valid_a(va1), .valid_b(vb1),
    .busy(busy1), .collision(col1));

  typedef struct {
    logic       en_a, we_a;
    logic [4:0] addr_a;
    logic [7:0] din_a;
    logic       en_b, we_b;
    logic [4:0] addr_b;
    logic [7:0] din_b;
    logic [7:0] exp_da;
    logic       exp_va;
    logic [7:0] exp_db;
    logic       exp_vb;
    logic       exp_col;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ea, input logic wa, input logic [4:0] aa, input logic [7:0] xa,
                              input logic eb, input logic wb, input logic [4:0] ab, input logic [7:0] xb,
                              input logic [7:0] qa, input logic qva, input logic [7:0] qb,
                              input logic qvb, input logic qc);
    vec_t v;
    v.en_a = ea; v.we_a = wa; v.addr_a = aa; v.din_a = xa;
    v.en_b = eb; v.we_b = wb; v.addr_b = ab; v.din_b = xb;
    v.exp_da = qa; v.exp_va = qva; v.exp_db = qb; v.exp_vb = qvb; v.exp_col = qc;
    return v;
  endfunction

  task automatic idle_all();
    en_a0 = 0; we_a0 = 0; addr_a0 = 0; din_a0 = 0; en_b0 = 0; we_b0 = 0; addr_b0 = 0; din_b0 = 0;
    en_a1 = 0; we_a1 = 0; addr_a1 = 0; din_a1 = 0; en_b1 = 0; we_b1 = 0; addr_b1 = 0; din_b1 = 0;
  endtask

  // Drive one vector on the chosen instance for one edge, then compare its
  // outputs as they stand just after that edge.
  task automatic run_vec(input int which, input int idx, input vec_t v);
    logic [7:0] a_da, a_db;
    logic       a_va, a_vb, a_col;
    idle_all();
    if (which == 0) begin
      en_a0 = v.en_a; we_a0 = v.we_a; addr_a0 = v.addr_a; din_a0 = v.din_a;
      en_b0 = v.en_b; we_b0 = v.we_b; addr_b0 = v.addr_b; din_b0 = v.din_b;
    end else begin
      en_a1 = v.en_a; we_a1 = v.we_a; addr_a1 = v.addr_a; din_a1 = v.din_a;
      en_b1 = v.en_b; we_b1 = v.we_b; addr_b1 = v.addr_b; din_b1 = v.din_b;
    end
    @(posedge clk); #1;
    if (which == 0) begin
      a_da = da0; a_va = va0; a_db = db0; a_vb = vb0; a_col = col0;
    end else begin
      a_da = da1; a_va = va1; a_db = db1; a_vb = vb1; a_col = col1;
    end
    chk($sformatf("t%0d[%0d] data_out_a", which, idx), 32'(a_da), 32'(v.exp_da));
    chk($sformatf("t%0d[%0d] valid_a", which, idx), 32'(a_va), 32'(v.exp_va));
    chk($sformatf("t%0d[%0d] data_out_b", which, idx), 32'(a_db), 32'(v.exp_db));
    chk($sformatf("t%0d[%0d] valid_b", which, idx), 32'(a_vb), 32'(v.exp_vb));
    chk($sformatf("t%0d[%0d] collision", which, idx), 32'(a_col), 32'(v.exp_col));
  endtask

  // Count edges until busy drops (rst already low); expect exactly 32 with no valid.
  task automatic wait_clear(input string nm);
    int  n;
    logic saw_valid;
    n = 0;
    saw_valid = 1'b0;
    while (busy0 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (va0 || vb0 || va1 || vb1) saw_valid = 1'b1;
    end
    chk({nm, " busy cycles"}, 32'(n), 32'd32);
    chk({nm, " u1 busy after clear"}, 32'(busy1), 32'd0);
    chk({nm, " valid during clear"}, 32'(saw_valid), 32'd0);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " da0"}, 32'(da0), 0);  chk({nm, " db0"}, 32'(db0), 0);
    chk({nm, " da1"}, 32'(da1), 0);  chk({nm, " db1"}, 32'(db1), 0);
    chk({nm, " valids"}, 32'({va0, vb0, va1, vb1}), 0);
    chk({nm, " collisions"}, 32'({col0, col1}), 0);
    chk({nm, " busy"}, 32'({busy0, busy1}), 32'd3);
  endtask

  vec_t t0[13];
  vec_t t1[10];

  initial begin
    //          A: en we addr din    B: en we addr din    exp: da  va  db  vb  col
    t0[0]  = mk(1, 0, 31, 8'h00,  0, 0, 0, 8'h00,  8'h00, 1, 8'h00, 0, 0);
    t0[1]  = mk(1, 1,  3, 8'hA5,  0, 0, 0, 8'h00,  8'hA5, 1, 8'h00, 0, 0);
    t0[2]  = mk(0, 0,  0, 8'h00,  1, 0, 3, 8'h00,  8'hA5, 0, 8'hA5, 1, 0);
    t0[3]  = mk(1, 1,  7, 8'h11,  1, 1, 7, 8'h22,  8'h11, 1, 8'h22, 1, 1);
    t0[4]  = mk(0, 0,  0, 8'h00,  0, 0, 0, 8'h00,  8'h11, 0, 8'h22, 0, 0);
    t0[5]  = mk(1, 0,  7, 8'h00,  0, 0, 0, 8'h00,  8'h11, 1, 8'h22, 0, 0);
    t0[6]  = mk(1, 1,  9, 8'h33,  0, 0, 0, 8'h00,  8'h33, 1, 8'h22, 0, 0);
    t0[7]  = mk(1, 0,  9, 8'h00,  1, 1, 9, 8'h44,  8'h33, 1, 8'h44, 1, 1);
    t0[8]  = mk(0, 0,  0, 8'h00,  1, 0, 9, 8'h00,  8'h33, 0, 8'h44, 1, 0);
    t0[9]  = mk(1, 0,  9, 8'h00,  1, 0, 9, 8'h00,  8'h44, 1, 8'h44, 1, 0);
    t0[10] = mk(1, 1,  0, 8'h55,  1, 0, 1, 8'h00,  8'h55, 1, 8'h00, 1, 0);
    t0[11] = mk(1, 0,  0, 8'h00,  1, 1, 31, 8'h66, 8'h55, 1, 8'h66, 1, 0);
    t0[12] = mk(1, 0, 31, 8'h00,  1, 0, 0, 8'h00,  8'h66, 1, 8'h55, 1, 0);
    // u1 expectations are the outputs two edges after the access (read-first).
    t1[0]  = mk(1, 1,  2, 8'h0F,  0, 0, 0, 8'h00,  8'h00, 0, 8'h00, 0, 0);
    t1[1]  = mk(1, 1,  2, 8'h5A,  0, 0, 0, 8'h00,  8'h00, 1, 8'h00, 0, 0);
    t1[2]  = mk(1, 0,  2, 8'h00,  0, 0, 0, 8'h00,  8'h0F, 1, 8'h00, 0, 0);
    t1[3]  = mk(1, 0,  0, 8'h00,  0, 0, 0, 8'h00,  8'h5A, 1, 8'h00, 0, 0);
    t1[4]  = mk(1, 0,  2, 8'h00,  0, 0, 0, 8'h00,  8'h00, 1, 8'h00, 0, 0);
    t1[5]  = mk(0, 0,  0, 8'h00,  0, 0, 0, 8'h00,  8'h5A, 1, 8'h00, 0, 0);
    t1[6]  = mk(0, 0,  0, 8'h00,  0, 0, 0, 8'h00,  8'h5A, 0, 8'h00, 0, 0);
    t1[7]  = mk(1, 0,  5, 8'h00,  1, 1, 5, 8'h77,  8'h5A, 0, 8'h00, 0, 0);
    t1[8]  = mk(0, 0,  0, 8'h00,  0, 0, 0, 8'h00,  8'h00, 1, 8'h00, 1, 1);
    t1[9]  = mk(0, 0,  0, 8'h00,  0, 0, 0, 8'h00,  8'h00, 0, 8'h00, 0, 0);

    idle_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");

    // Release reset; u0 port A requests reads throughout the clear, all ignored.
    rst = 1'b0;
    en_a0 = 1; addr_a0 = 5'd31;
    wait_clear("clear1");
    idle_all();

    for (int i = 0; i < 13; i++) run_vec(0, i, t0[i]);
    for (int i = 0; i < 10; i++) run_vec(1, i, t1[i]);

    // Reset 10 cycles into a clear.
    idle_all();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midclear busy before rst", 32'(busy0), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("midclear rst");
    rst = 1'b0;
    wait_clear("clear2");

    // Reset with a read in flight in u1's two-stage pipeline.
    en_a1 = 1; addr_a1 = 5'd2;
    @(posedge clk); #1;
    chk("inflight valid_a1 at +1", 32'(va1), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("inflight rst");
    rst = 1'b0;
    idle_all();
    wait_clear("clear3");

    // After the restarted clear the word last written 0x5A reads back 0.
    en_a1 = 1; addr_a1 = 5'd2;
    @(posedge clk); #1;
    idle_all();
    @(posedge clk); #1;
    chk("post clear u1 data_out_a", 32'(da1), 32'h00);
    chk("post clear u1 valid_a", 32'(va1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_dualport_param.md
RAM_DUALPORT_PARAM -- requirements
Module: ram_dualport_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 8, word width in bits.
- ADDR_W, 5, address width in bits; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, same-port read-during-write: 0 = write-first, 1 = read-first.
- OUT_REG, 0, 1 adds one output register stage on both ports.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- en_a / en_b, in, 1, port access enable.
- we_a / we_b, in, 1, write when 1, read when 0; qualified by en.
- addr_a / addr_b, in, ADDR_W, word address.
- data_in_a / data_in_b, in, DATA_W, write data.
- data_out_a / data_out_b, out, DATA_W, read or write-through data.
- valid_a / valid_b, out, 1, data_out holds data from an accepted access.
- busy, out, 1, memory-clear in progress; accesses ignored.
- collision, out, 1, same-address conflict flag, one pulse per conflict.

Function
REQ-003 Control SHALL be a two-state FSM, CLEAR and READY; rst forces CLEAR with clear counter = 0.
REQ-004 In CLEAR, the block SHALL write 0 to word[counter] each cycle and increment counter; after word DEPTH-1 is written it SHALL enter READY, so CLEAR lasts exactly DEPTH cycles.
REQ-005 busy SHALL be 1 in CLEAR and 0 in READY; en_a and en_b SHALL be ignored while busy = 1 (no write, no valid).
REQ-006 In READY, an access is accepted when en_x = 1; en_x = 0 SHALL leave data_out_x unchanged and drive valid_x low at its pipeline slot.
REQ-007 Accepted write: word[addr_x] <= data_in_x; data_out_x SHALL show data_in_x if RDW_MODE = 0, or the prior word[addr_x] if RDW_MODE = 1.
REQ-008 Accepted read: data_out_x SHALL show word[addr_x] as it was before this edge's writes, except as set by REQ-010.
REQ-009 Latency from the accepting edge SHALL be 1 cycle if OUT_REG = 0 and 2 cycles if OUT_REG = 1; valid_x SHALL be aligned with data_out_x; back-to-back accesses SHALL be accepted every cycle.
REQ-010 Cross-port read and write to the same address in one cycle: the reader SHALL return the old word (read-first across ports).
REQ-011 Both ports write the same address in one cycle: port A data SHALL be stored, port B data discarded; each port's data_out SHALL still follow REQ-007 for its own data_in.
REQ-012 collision SHALL pulse for 1 cycle, with port-A read latency, when both ports are accepted on equal addresses and at least one is a write; two reads SHALL NOT flag.
REQ-013 Addresses SHALL be unsigned and cover 0..DEPTH-1 with no wrap or out-of-range case; the clear counter SHALL be ADDR_W+1 bits wide to detect completion.

Reset
REQ-014 While rst = 1, on every edge the block SHALL force: data_out_a = data_out_b = 0; valid_a = valid_b = 0; collision = 0; busy = 1; FSM = CLEAR; counter = 0.
REQ-015 rst asserted mid-operation SHALL flush all pipeline stages (no valid on the following edges) and restart the full clear, even if one was in progress.
REQ-016 Memory contents SHALL be defined only through the clear; after READY is reached, every word reads 0 until written.

Verification
REQ-017 The bench SHALL cover these directed scenarios (defaults, OUT_REG = 0 unless noted):
- Release rst -> busy = 1 for exactly 32 cycles, then 0; a read of addr 31 returns 0x00 with valid_a = 1 one cycle later.
- Port A writes 0xA5 to addr 3, then port B reads addr 3 on the next cycle -> data_out_b = 0xA5, valid_b = 1, one cycle after the read.
- Same cycle, A writes 0x11 and B writes 0x22, both to addr 7 -> collision pulses once; a later read of addr 7 returns 0x11.
- Same cycle, A reads addr 9 (holding 0x33) and B writes 0x44 to addr 9 -> data_out_a = 0x33, collision = 1; the next read returns 0x44.
- RDW_MODE = 1, OUT_REG = 1: write 0x5A to addr 2 (holding 0x0F) -> data_out_a = 0x0F with valid_a at +2 cycles; streaming reads return one word per cycle.
- rst asserted 10 cycles into the clear, and again with reads in flight -> no valid pulses, busy = 1, full 32-cycle clear restarts.
